// File: rtl/reg_write_arbiter_if.sv
// Bus between the requesters and the register-file write-port arbiter.
// The arbiter side uses the slave modport; the requester side uses master.
interface reg_write_arbiter_if #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
);
    localparam int unsigned IdxW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ-1:0]            lock;
    logic [NUM_REQ*ADDR_WIDTH-1:0] addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] data;
    logic [NUM_REQ-1:0]            ack;
    logic                          wr_en;
    logic [ADDR_WIDTH-1:0]         wr_addr;
    logic [DATA_WIDTH-1:0]         wr_data;
    logic [IdxW-1:0]               owner;
    logic                          busy;

    modport master (
        output req, lock, addr, data,
        input  ack, wr_en, wr_addr, wr_data, owner, busy
    );

    modport slave (
        input  req, lock, addr, data,
        output ack, wr_en, wr_addr, wr_data, owner, busy
    );
endinterface

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing one register-file write port, with a lock that lets
// one requester keep the port across consecutive writes.
module reg_write_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input logic                clk,
    input logic                clear_n,
    reg_write_arbiter_if.slave bus
);
    localparam int unsigned IdxW = $clog2(NUM_REQ);

    typedef enum logic {StIdle, StLocked} state_e;

    state_e                  state_q, state_d;
    logic [IdxW-1:0]         ptr_q;
    logic [IdxW-1:0]         owner_q;
    logic                    wr_en_q;
    logic [ADDR_WIDTH-1:0]   wr_addr_q;
    logic [DATA_WIDTH-1:0]   wr_data_q;

    logic [NUM_REQ-1:0]      grant;
    logic [NUM_REQ-1:0]      ack;
    logic [IdxW-1:0]         grant_idx;
    logic [IdxW:0]           cand;
    logic                    found;
    logic                    xfer;
    logic                    sel_lock;
    logic [IdxW-1:0]         ptr_next;

    // State register
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (xfer && sel_lock) state_d = StLocked;
            end
            StLocked: begin
                // Without a transfer req[owner] is low, so only the lock hint matters.
                if (xfer) begin
                    if (!sel_lock) state_d = StIdle;
                end else if (!bus.lock[owner_q]) begin
                    state_d = StIdle;
                end
            end
        endcase
    end

    // Grant / output logic
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        cand      = '0;
        found     = 1'b0;
        if (state_q == StLocked) begin
            grant_idx        = owner_q;
            grant[owner_q]   = bus.req[owner_q];
        end else begin
            for (int k = 0; k < int'(NUM_REQ); k++) begin
                cand = {1'b0, ptr_q} + (IdxW+1)'(k);
                if (cand >= (IdxW+1)'(NUM_REQ)) cand = cand - (IdxW+1)'(NUM_REQ);
                if (!found && bus.req[cand[IdxW-1:0]]) begin
                    found                   = 1'b1;
                    grant_idx               = cand[IdxW-1:0];
                    grant[cand[IdxW-1:0]]   = 1'b1;
                end
            end
        end
        ack = grant & {NUM_REQ{clear_n}};
    end

    assign xfer     = |(bus.req & ack);
    assign sel_lock = bus.lock[grant_idx];
    assign ptr_next = (grant_idx == IdxW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            ptr_q     <= '0;
            owner_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en_q <= xfer;
            if (xfer) begin
                wr_addr_q <= bus.addr[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
                wr_data_q <= bus.data[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
            end
            // Pointer and owner are frozen while the port is locked.
            if (xfer && state_q == StIdle) begin
                ptr_q   <= ptr_next;
                owner_q <= grant_idx;
            end
        end
    end

    assign bus.ack     = ack;
    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;
    assign bus.owner   = owner_q;
    assign bus.busy    = (state_q == StLocked);

`ifndef SYNTHESIS
    logic [NUM_REQ-1:0] owner_mask;
    assign owner_mask = NUM_REQ'(1) << owner_q;

    a_ack_onehot0: assert property (@(posedge clk) $onehot0(ack));
    a_wr_latency: assert property (@(posedge clk) disable iff (!clear_n)
        wr_en_q == $past(xfer));
    a_locked_excl: assert property (@(posedge clk) disable iff (!clear_n)
        bus.busy |-> ((ack & ~owner_mask) == '0));
`endif
endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter: round-robin order, lock handling,
// write latency and asynchronous reset.
module tb_reg_write_arbiter;
    localparam int unsigned NUM_REQ    = 4;
    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned ADDR_WIDTH = 5;

    logic clk;
    logic clear_n;
    int   n_vec;
    int   n_err;

    reg_write_arbiter_if #(
        .NUM_REQ    (NUM_REQ),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) bus ();

    reg_write_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) dut (
        .clk     (clk),
        .clear_n (clear_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int i, input logic [ADDR_WIDTH-1:0] a,
                            input logic [DATA_WIDTH-1:0] d);
        bus.addr[i*ADDR_WIDTH +: ADDR_WIDTH] = a;
        bus.data[i*DATA_WIDTH +: DATA_WIDTH] = d;
    endtask

    task automatic check_wr(input string tag, input logic [ADDR_WIDTH-1:0] a,
                            input logic [DATA_WIDTH-1:0] d, input logic [1:0] own);
        check_eq({tag, ".wr_en"},   bus.wr_en,   1);
        check_eq({tag, ".wr_addr"}, bus.wr_addr, a);
        check_eq({tag, ".wr_data"}, bus.wr_data, d);
        check_eq({tag, ".owner"},   bus.owner,   own);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        n_vec    = 0;
        n_err    = 0;
        clear_n  = 1'b0;
        bus.req  = 4'b1111;
        bus.lock = '0;
        bus.addr = '0;
        bus.data = '0;

        // Reset: registered outputs cleared, ack suppressed even with requests pending
        #1;
        check_eq("rst.ack", bus.ack, 0);
        tick();
        tick();
        check_eq("rst.wr_en",   bus.wr_en,   0);
        check_eq("rst.wr_addr", bus.wr_addr, 0);
        check_eq("rst.wr_data", bus.wr_data, 0);
        check_eq("rst.owner",   bus.owner,   0);
        check_eq("rst.busy",    bus.busy,    0);
        bus.req = '0;
        #3;
        clear_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1;
            check_eq("idle.ack", bus.ack, 0);
            tick();
            check_eq("idle.wr_en", bus.wr_en, 0);
        end

        // Single requester 2
        set_port(2, 5'd7, 32'hDEADBEEF);
        bus.req = 4'b0100;
        #1;
        check_eq("single.ack", bus.ack, 4'b0100);
        tick();
        check_wr("single", 5'd7, 32'hDEADBEEF, 2'd2);
        check_eq("single.busy", bus.busy, 0);

        // Requester 3 alone: pointer moves from 3 to 0
        set_port(3, 5'd3, 32'h0000_0333);
        bus.req = 4'b1000;
        #1;
        check_eq("r3.ack", bus.ack, 4'b1000);
        tick();
        check_wr("r3", 5'd3, 32'h0000_0333, 2'd3);

        // All four requesting: strict rotation 0,1,2,3,0,1,2,3
        for (int i = 0; i < 4; i++) set_port(i, 5'(10 + i), 32'hA000_0000 + 32'(i));
        bus.req = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            #1;
            check_eq("rr.ack", bus.ack, 4'b0001 << (k % 4));
            tick();
            check_wr("rr", 5'(10 + k % 4), 32'hA000_0000 + 32'(k % 4), 2'(k % 4));
        end
        bus.req = '0;
        tick();
        check_eq("rr.drain.wr_en", bus.wr_en, 0);

        // Lock by requester 1 for three writes while 0 and 3 wait
        set_port(1, 5'd1, 32'h1111_0001);
        set_port(0, 5'd16, 32'h0000_0F00);
        set_port(3, 5'd19, 32'h0000_0F03);
        bus.req  = 4'b0010;
        bus.lock = 4'b0010;
        #1;
        check_eq("lk1.ack", bus.ack, 4'b0010);
        tick();
        check_wr("lk1", 5'd1, 32'h1111_0001, 2'd1);
        check_eq("lk1.busy", bus.busy, 1);
        set_port(1, 5'd2, 32'h1111_0002);
        bus.req = 4'b1011;
        #1;
        check_eq("lk2.ack", bus.ack, 4'b0010);
        tick();
        check_wr("lk2", 5'd2, 32'h1111_0002, 2'd1);
        check_eq("lk2.busy", bus.busy, 1);
        set_port(1, 5'd3, 32'h1111_0003);
        bus.lock = 4'b0000;
        #1;
        check_eq("lk3.ack", bus.ack, 4'b0010);
        tick();
        check_wr("lk3", 5'd3, 32'h1111_0003, 2'd1);
        check_eq("lk3.busy", bus.busy, 0);
        // Pointer is 2, so the search wraps to requester 3 before 0
        bus.req = 4'b1001;
        #1;
        check_eq("lk.after.ack", bus.ack, 4'b1000);
        tick();
        check_wr("lk.after", 5'd19, 32'h0000_0F03, 2'd3);
        bus.req = '0;

        // Locked owner 2 idles with lock held while requester 0 waits
        set_port(2, 5'd20, 32'h2222_0000);
        bus.req  = 4'b0100;
        bus.lock = 4'b0100;
        #1;
        check_eq("li.ack", bus.ack, 4'b0100);
        tick();
        check_wr("li", 5'd20, 32'h2222_0000, 2'd2);
        check_eq("li.busy", bus.busy, 1);
        bus.req = 4'b0001;
        for (int c = 0; c < 5; c++) begin
            #1;
            check_eq("li.hold.ack", bus.ack, 0);
            tick();
            check_eq("li.hold.wr_en", bus.wr_en, 0);
            check_eq("li.hold.busy",  bus.busy,  1);
        end
        bus.lock = 4'b0000;
        #1;
        check_eq("li.drop.ack", bus.ack, 0);
        tick();
        check_eq("li.drop.wr_en", bus.wr_en, 0);
        check_eq("li.drop.busy",  bus.busy,  0);
        #1;
        check_eq("li.next.ack", bus.ack, 4'b0001);
        tick();
        check_wr("li.next", 5'd16, 32'h0000_0F00, 2'd0);
        bus.req = '0;

        // Asynchronous reset in the middle of a lock held by requester 1
        set_port(1, 5'd9, 32'h9999_0009);
        bus.req  = 4'b0010;
        bus.lock = 4'b0010;
        #1;
        check_eq("ar.ack", bus.ack, 4'b0010);
        tick();
        check_wr("ar", 5'd9, 32'h9999_0009, 2'd1);
        check_eq("ar.busy", bus.busy, 1);
        bus.req = '0;
        #3;
        clear_n = 1'b0;
        #1;
        check_eq("ar.rst.busy",    bus.busy,    0);
        check_eq("ar.rst.wr_en",   bus.wr_en,   0);
        check_eq("ar.rst.owner",   bus.owner,   0);
        check_eq("ar.rst.wr_addr", bus.wr_addr, 0);
        tick();
        #3;
        clear_n  = 1'b1;
        bus.lock = '0;
        // Pointer back at 0: requester 1 wins over 3
        bus.req  = 4'b1010;
        #1;
        check_eq("ar.rel.ack", bus.ack, 4'b0010);
        tick();
        check_wr("ar.rel", 5'd9, 32'h9999_0009, 2'd1);
        check_eq("ar.rel.busy", bus.busy, 0);
        bus.req = 4'b1000;
        #1;
        check_eq("ar.r3.ack", bus.ack, 4'b1000);
        tick();
        check_wr("ar.r3", 5'd19, 32'h0000_0F03, 2'd3);
        bus.req = '0;
        tick();
        check_eq("end.wr_en", bus.wr_en, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
